// File: rtl/keycode_action_tracker_if.sv
// -----------------------------------------------------------------------------
// keycode_action_tracker_if
//
// Purpose: groups the frame strobe, HID keycode slots and the registered
// shooter outputs of keycode_action_tracker into one bundle.
//
// Signals:
//   frame_tick   one-clock strobe per video frame (driven by master)
//   keycodes     NUM_KEYS packed 8-bit keycode slots, 8'h00 = empty (master)
//   ShooterMove  resolved movement direction, 3 bits (slave)
//   is_shot      one-clock shot pulse (slave)
//   fire_ready   high while a fresh fire press would fire (slave)
//
// Modports:
//   master  drives frame_tick/keycodes, observes the outputs
//   slave   the tracker itself
// -----------------------------------------------------------------------------
interface keycode_action_tracker_if #(
    parameter int NUM_KEYS = 6
);
    logic                    frame_tick;
    logic [8*NUM_KEYS-1:0]   keycodes;
    logic [2:0]              ShooterMove;
    logic                    is_shot;
    logic                    fire_ready;

    modport master (
        output frame_tick,
        output keycodes,
        input  ShooterMove,
        input  is_shot,
        input  fire_ready
    );

    modport slave (
        input  frame_tick,
        input  keycodes,
        output ShooterMove,
        output is_shot,
        output fire_ready
    );
endinterface

// File: rtl/keycode_action_tracker.sv
// -----------------------------------------------------------------------------
// keycode_action_tracker
//
// Purpose: frame-synchronous keycode decoder for the shooter. Scans NUM_KEYS
// USB HID keycode slots, resolves movement as most-recent-press-wins (ties
// broken by lowest slot index) and turns the spacebar into rate-limited,
// one-clock shot pulses. All state advances only on frame_tick; all outputs
// are registered and appear one clock after the tick.
//
// Ports:
//   Clk    system clock
//   Reset  synchronous, active-high reset
//   bus    keycode_action_tracker_if.slave
//            frame_tick, keycodes            inputs
//            ShooterMove, is_shot, fire_ready outputs
//
// Parameters:
//   NUM_KEYS       keycode slots (slot 0 = highest static priority)
//   FIRE_COOLDOWN  frame ticks between consecutive shots (>= 1)
//   CNT_W          cooldown counter width, FIRE_COOLDOWN < 2**CNT_W
//
// Build option:
//   KEYCODE_AUTOFIRE_EN  when defined, holding fire re-fires every
//                        FIRE_COOLDOWN ticks; otherwise one shot per press.
//
// Movement codes: 000 none, 001 up (1a), 010 right (07), 011 down (16),
// 100 left (04). Fire key is 2c.
// -----------------------------------------------------------------------------
module keycode_action_tracker #(
    parameter int NUM_KEYS      = 6,
    parameter int FIRE_COOLDOWN = 8,
    parameter int CNT_W         = 4
) (
    input logic                    Clk,
    input logic                    Reset,
    keycode_action_tracker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COOLDOWN = 2'd1,
        WAIT_REL = 2'd2
    } fire_state_t;

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_DOWN  = 3'd3;
    localparam logic [2:0] DIR_LEFT  = 3'd4;

    localparam logic [7:0] KEY_W     = 8'h1a;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_SPACE = 8'h2c;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FIRE_COOLDOWN - 1);

    // Map a single keycode to its movement direction (DIR_NONE if not movement).
    function automatic logic [2:0] dir_of(input logic [7:0] code);
        logic [2:0] d;
        case (code)
            KEY_W:   d = DIR_UP;
            KEY_D:   d = DIR_RIGHT;
            KEY_S:   d = DIR_DOWN;
            KEY_A:   d = DIR_LEFT;
            default: d = DIR_NONE;
        endcase
        return d;
    endfunction

    // Direction found in the lowest slot whose direction bit is set in mask.
    // Scanning downward lets the lowest index overwrite any higher one.
    function automatic logic [2:0] pick_lowest(
        input logic [8*NUM_KEYS-1:0] codes,
        input logic [7:0]            mask
    );
        logic [2:0] d;
        logic [2:0] res;
        res = DIR_NONE;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            d = dir_of(codes[8*i +: 8]);
            if (d != DIR_NONE && mask[d]) begin
                res = d;
            end
        end
        return res;
    endfunction

    // held_dir is indexed directly by the 3-bit direction code; bits for
    // codes 0 and 5..7 stay zero so lookups never need range adjustment.
    logic [7:0]       held_dir;
    logic             held_fire;
    logic [7:0]       rise_dir;
    logic             rise_fire;
    logic [2:0]       rise_pick;
    logic [2:0]       held_pick;
    logic [2:0]       last_dir_n;

    logic [7:0]       prev_held_p0;
    logic             prev_fire_p0;
    logic [2:0]       last_dir_p0;
    logic             is_shot_p0;
    logic             fire_ready_p0;

    fire_state_t      state_p0;
    fire_state_t      state_n;
    logic [CNT_W-1:0] cnt_p0;
    logic [CNT_W-1:0] cnt_n;
    logic             shot_n;

    // Presence decode: a key in any slot counts, duplicates collapse.
    always_comb begin
        held_dir  = '0;
        held_fire = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (dir_of(bus.keycodes[8*i +: 8]) != DIR_NONE) begin
                held_dir[dir_of(bus.keycodes[8*i +: 8])] = 1'b1;
            end
            if (bus.keycodes[8*i +: 8] == KEY_SPACE) begin
                held_fire = 1'b1;
            end
        end
    end

    assign rise_dir  = held_dir & ~prev_held_p0;
    assign rise_fire = held_fire & ~prev_fire_p0;
    assign rise_pick = pick_lowest(bus.keycodes, rise_dir);
    assign held_pick = pick_lowest(bus.keycodes, held_dir);

    // Newest press wins; while it stays held it sticks; once released we
    // fall back to whatever is still held, lowest slot first.
    always_comb begin
        last_dir_n = last_dir_p0;
        if (|rise_dir) begin
            last_dir_n = rise_pick;
        end else if (last_dir_p0 != DIR_NONE && held_dir[last_dir_p0]) begin
            last_dir_n = last_dir_p0;
        end else begin
            last_dir_n = held_pick;
        end
    end

    // Fire FSM next-state and shot decision; nothing moves without a tick.
    always_comb begin
        state_n = state_p0;
        cnt_n   = cnt_p0;
        shot_n  = 1'b0;
        if (bus.frame_tick) begin
            case (state_p0)
                IDLE: begin
                    if (rise_fire) begin
                        shot_n  = 1'b1;
                        cnt_n   = CNT_RELOAD;
                        state_n = COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    if (cnt_p0 != '0) begin
                        cnt_n = cnt_p0 - CNT_W'(1);
                    end else if (held_fire) begin
`ifdef KEYCODE_AUTOFIRE_EN
                        shot_n  = 1'b1;
                        cnt_n   = CNT_RELOAD;
                        state_n = COOLDOWN;
`else
                        state_n = WAIT_REL;
`endif
                    end else begin
                        state_n = IDLE;
                    end
                end
                WAIT_REL: begin
                    if (!held_fire) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Stage p0: fire FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_p0 <= IDLE;
            cnt_p0   <= '0;
        end else begin
            state_p0 <= state_n;
            cnt_p0   <= cnt_n;
        end
    end

    // Stage p0: edge history, movement and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_held_p0  <= '0;
            prev_fire_p0  <= 1'b0;
            last_dir_p0   <= DIR_NONE;
            is_shot_p0    <= 1'b0;
            fire_ready_p0 <= 1'b1;
        end else begin
            is_shot_p0    <= shot_n;
            fire_ready_p0 <= (state_n == IDLE);
            if (bus.frame_tick) begin
                prev_held_p0 <= held_dir;
                prev_fire_p0 <= held_fire;
                last_dir_p0  <= last_dir_n;
            end
        end
    end

    assign bus.ShooterMove = last_dir_p0;
    assign bus.is_shot     = is_shot_p0;
    assign bus.fire_ready  = fire_ready_p0;

endmodule

// File: tb/tb_keycode_action_tracker.sv
module tb_keycode_action_tracker;

    localparam int NUM_KEYS      = 6;
    localparam int FIRE_COOLDOWN = 8;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    keycode_action_tracker_if #(.NUM_KEYS(NUM_KEYS)) bus ();

    keycode_action_tracker #(
        .NUM_KEYS(NUM_KEYS),
        .FIRE_COOLDOWN(FIRE_COOLDOWN),
        .CNT_W(4)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Raise frame_tick for one clock; returns at the falling edge after the
    // tick was sampled, so outputs reflect that tick.
    task automatic tick();
        @(negedge Clk);
        bus.frame_tick = 1'b1;
        @(negedge Clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic set_slot(input int idx, input logic [7:0] code);
        bus.keycodes[8*idx +: 8] = code;
    endtask

    task automatic clear_keys();
        bus.keycodes = '0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.frame_tick = 1'b0;
        clear_keys();
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (bus.ShooterMove !== 3'b000) begin
            errors++; $display("FAIL reset_move got %b exp 000", bus.ShooterMove);
        end
        checks++;
        if (bus.is_shot !== 1'b0) begin
            errors++; $display("FAIL reset_shot got %b exp 0", bus.is_shot);
        end
        checks++;
        if (bus.fire_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b exp 1", bus.fire_ready);
        end
        // Tick during reset must not update anything.
        set_slot(0, 8'h07);
        Reset = 1'b1;
        bus.frame_tick = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        bus.frame_tick = 1'b0;
        @(negedge Clk);
        checks++;
        if (bus.ShooterMove !== 3'b000) begin
            errors++; $display("FAIL reset_wins_tick got %b exp 000", bus.ShooterMove);
        end
    endtask

    task automatic test_single_dir();
        // slot0 = 07 still set; no tick yet -> outputs hold.
        repeat (3) @(negedge Clk);
        checks++;
        if (bus.ShooterMove !== 3'b000) begin
            errors++; $display("FAIL hold_no_tick got %b exp 000", bus.ShooterMove);
        end
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if (bus.ShooterMove !== 3'b010) begin
                errors++; $display("FAIL right_tick%0d got %b exp 010", t, bus.ShooterMove);
            end
            checks++;
            if (bus.is_shot !== 1'b0) begin
                errors++; $display("FAIL right_noshot%0d got %b exp 0", t, bus.is_shot);
            end
        end
        clear_keys();
        tick();
        checks++;
        if (bus.ShooterMove !== 3'b000) begin
            errors++; $display("FAIL release_none got %b exp 000", bus.ShooterMove);
        end
    endtask

    task automatic test_recent_wins();
        set_slot(0, 8'h04);
        tick();
        checks++;
        if (bus.ShooterMove !== 3'b100) begin
            errors++; $display("FAIL left_press got %b exp 100", bus.ShooterMove);
        end
        set_slot(3, 8'h1a);
        tick();
        checks++;
        if (bus.ShooterMove !== 3'b001) begin
            errors++; $display("FAIL up_newer got %b exp 001", bus.ShooterMove);
        end
        tick();
        checks++;
        if (bus.ShooterMove !== 3'b001) begin
            errors++; $display("FAIL up_sticks got %b exp 001", bus.ShooterMove);
        end
        set_slot(3, 8'h00);
        tick();
        checks++;
        if (bus.ShooterMove !== 3'b100) begin
            errors++; $display("FAIL fallback_left got %b exp 100", bus.ShooterMove);
        end
        // Opposing key pressed while left held: newest wins, no cancel.
        set_slot(5, 8'h07);
        tick();
        checks++;
        if (bus.ShooterMove !== 3'b010) begin
            errors++; $display("FAIL opposing_right got %b exp 010", bus.ShooterMove);
        end
        clear_keys();
        tick();
    endtask

    task automatic test_same_tick_rise();
        set_slot(1, 8'h16);
        set_slot(4, 8'h1a);
        set_slot(2, 8'h16);
        tick();
        checks++;
        if (bus.ShooterMove !== 3'b011) begin
            errors++; $display("FAIL lowest_slot got %b exp 011", bus.ShooterMove);
        end
        clear_keys();
        tick();
        checks++;
        if (bus.ShooterMove !== 3'b000) begin
            errors++; $display("FAIL both_released got %b exp 000", bus.ShooterMove);
        end
    endtask

    // Release fire and tick until fire_ready returns; returns tick count.
    task automatic wait_ready(output int n);
        n = 0;
        while (bus.fire_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.fire_ready !== 1'b1) begin
            errors++; $display("FAIL ready_timeout got %b exp 1", bus.fire_ready);
        end
    endtask

    task automatic test_fire_hold();
        int  shots;
        int  n;
        logic exp_shot;
        shots = 0;
        set_slot(2, 8'h2c);
        for (int k = 0; k < 20; k++) begin
`ifdef KEYCODE_AUTOFIRE_EN
            exp_shot = ((k % FIRE_COOLDOWN) == 0);
`else
            exp_shot = (k == 0);
`endif
            tick();
            if (bus.is_shot === 1'b1) shots++;
            checks++;
            if (bus.is_shot !== exp_shot) begin
                errors++; $display("FAIL hold_shot_t%0d got %b exp %b", k, bus.is_shot, exp_shot);
            end
            @(negedge Clk);
            checks++;
            if (bus.is_shot !== 1'b0) begin
                errors++; $display("FAIL pulse_width_t%0d got %b exp 0", k, bus.is_shot);
            end
        end
        checks++;
`ifdef KEYCODE_AUTOFIRE_EN
        if (shots != 3) begin
            errors++; $display("FAIL shot_count got %0d exp 3", shots);
        end
`else
        if (shots != 1) begin
            errors++; $display("FAIL shot_count got %0d exp 1", shots);
        end
`endif
        checks++;
        if (bus.fire_ready !== 1'b0) begin
            errors++; $display("FAIL ready_while_held got %b exp 0", bus.fire_ready);
        end
        clear_keys();
        wait_ready(n);
`ifndef KEYCODE_AUTOFIRE_EN
        checks++;
        if (n != 1) begin
            errors++; $display("FAIL release_ticks got %0d exp 1", n);
        end
`endif
    endtask

    task automatic test_repress_ignored();
        int n;
        set_slot(0, 8'h2c);
        tick();
        checks++;
        if (bus.is_shot !== 1'b1) begin
            errors++; $display("FAIL repress_first got %b exp 1", bus.is_shot);
        end
        clear_keys();
        tick();
        set_slot(0, 8'h2c);
        tick();
        checks++;
        if (bus.is_shot !== 1'b0) begin
            errors++; $display("FAIL repress_cooldown got %b exp 0", bus.is_shot);
        end
        clear_keys();
        wait_ready(n);
    endtask

    task automatic test_reset_mid_cooldown();
        set_slot(0, 8'h07);
        set_slot(1, 8'h2c);
        tick();
        checks++;
        if (bus.is_shot !== 1'b1 || bus.ShooterMove !== 3'b010) begin
            errors++; $display("FAIL combo_press got shot=%b move=%b exp 1/010", bus.is_shot, bus.ShooterMove);
        end
        tick();
        tick();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        checks++;
        if (bus.ShooterMove !== 3'b000 || bus.is_shot !== 1'b0 || bus.fire_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset got move=%b shot=%b ready=%b exp 000/0/1",
                               bus.ShooterMove, bus.is_shot, bus.fire_ready);
        end
        tick();
        checks++;
        if (bus.is_shot !== 1'b1) begin
            errors++; $display("FAIL post_reset_shot got %b exp 1", bus.is_shot);
        end
        checks++;
        if (bus.ShooterMove !== 3'b010) begin
            errors++; $display("FAIL post_reset_move got %b exp 010", bus.ShooterMove);
        end
        checks++;
        if (bus.fire_ready !== 1'b0) begin
            errors++; $display("FAIL post_reset_ready got %b exp 0", bus.fire_ready);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset = 1'b1;
        bus.frame_tick = 1'b0;
        bus.keycodes = '0;
        test_reset();
        test_single_dir();
        test_recent_wins();
        test_same_tick_rise();
        test_fire_hold();
        test_repress_ignored();
        test_reset_mid_cooldown();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
